// File: rtl/hdpldadapt_rx_cp_bond_pkg.sv
// Shared definitions for the RX control-plane bonding read sequencer.
package hdpldadapt_rx_cp_bond_pkg;

    // Default width of the start-delay / alignment-timeout counter
    localparam int BOND_CNTWIDTH = 8;

    // Sequencer states; the encoding is visible on the testbus
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELAY = 3'd1,
        ST_ARM   = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERR   = 3'd4
    } bond_state_e;

endpackage

// File: rtl/hdpldadapt_cmn_load_dncntr.sv
// Loadable down-counter that saturates at zero (never wraps).
module hdpldadapt_cmn_load_dncntr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             is_zero
);

    logic [WIDTH-1:0] count;

    assign is_zero = (count == '0);

    // clear beats load beats decrement; decrement only while non-zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && !is_zero)
            count <= count - WIDTH'(1);
    end

endmodule

// File: rtl/hdpldadapt_rx_cp_bond_rdctl.sv
// Read-side start-up sequencer for the bonded RX FIFO. Waits a programmed
// delay after write activity, drives the master read-enable into the bonding
// chain, and checks that the compensated enable comes back and stays up.
module hdpldadapt_rx_cp_bond_rdctl
    import hdpldadapt_rx_cp_bond_pkg::*;
#(
    parameter int CNTWIDTH = BOND_CNTWIDTH
) (
    input  logic                rx_rdfifo_clk,
    input  logic                rx_rdfifo_clk_rst_n,
    input  logic                rd_srst_n,
    input  logic                r_bond_en,
    input  logic                r_master_sel,
    input  logic                r_double_read,
    input  logic [CNTWIDTH-1:0] r_rd_delay,
    input  logic [CNTWIDTH-1:0] r_align_timeout,
    input  logic                wr_started,
    input  logic                fifo_empty,
    input  logic                comp_rden_en,
    output logic                master_in_rden,
    output logic                rd_phase,
    output logic                rd_align_done,
    output logic                bond_err,
    output logic [2:0]          bond_state
);

    bond_state_e         state_q, state_nxt;
    logic                cnt_clr, cnt_load, cnt_dec, cnt_zero;
    logic [CNTWIDTH-1:0] cnt_load_val;
    logic                phase_nxt;

    // One counter serves both the start delay and the alignment timeout
    hdpldadapt_cmn_load_dncntr #(.WIDTH(CNTWIDTH)) u_cnt (
        .clk      (rx_rdfifo_clk),
        .rst_n    (rx_rdfifo_clk_rst_n),
        .clr      (cnt_clr | ~rd_srst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .is_zero  (cnt_zero)
    );

    // Next-state and counter control
    always_comb begin
        state_nxt    = state_q;
        cnt_clr      = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = r_rd_delay;
        if (!r_bond_en) begin
            state_nxt = ST_IDLE;
            cnt_clr   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_clr = 1'b1;
                    if (wr_started) begin
                        cnt_clr   = 1'b0;
                        cnt_load  = 1'b1;
                        state_nxt = ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (!wr_started) begin
                        cnt_clr   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else if (cnt_zero) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = r_align_timeout;
                        state_nxt    = ST_ARM;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_ARM: begin
                    // alignment arriving on the last timeout cycle still counts
                    if (comp_rden_en)
                        state_nxt = ST_RUN;
                    else if (cnt_zero)
                        state_nxt = ST_ERR;
                    else
                        cnt_dec = 1'b1;
                end
                ST_RUN: begin
                    // underflow, or the chain losing its enable, is fatal
                    if (!comp_rden_en || fifo_empty)
                        state_nxt = ST_ERR;
                end
                ST_ERR:  state_nxt = ST_ERR;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Phase toggles only while staying in RUN with the enable present
    always_comb begin
        phase_nxt = 1'b0;
        if (state_q == ST_RUN && state_nxt == ST_RUN && r_double_read)
            phase_nxt = ~rd_phase;
    end

    // State and registered outputs, all derived from the next state
    always_ff @(posedge rx_rdfifo_clk or negedge rx_rdfifo_clk_rst_n) begin
        if (!rx_rdfifo_clk_rst_n) begin
            state_q        <= ST_IDLE;
            master_in_rden <= 1'b0;
            rd_align_done  <= 1'b0;
            rd_phase       <= 1'b0;
            bond_err       <= 1'b0;
        end else if (!rd_srst_n) begin
            state_q        <= ST_IDLE;
            master_in_rden <= 1'b0;
            rd_align_done  <= 1'b0;
            rd_phase       <= 1'b0;
            bond_err       <= 1'b0;
        end else begin
            state_q        <= state_nxt;
            master_in_rden <= r_master_sel &&
                              (state_nxt == ST_ARM || state_nxt == ST_RUN);
            rd_align_done  <= (state_nxt == ST_RUN);
            rd_phase       <= phase_nxt;
            bond_err       <= bond_err | (state_nxt == ST_ERR);
        end
    end

    assign bond_state = state_q;

endmodule

// File: tb/tb_hdpldadapt_rx_cp_bond_rdctl.sv
// Directed bench for the bonded RX read start-up sequencer.
module tb_hdpldadapt_rx_cp_bond_rdctl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rd_srst_n = 1'b1;
    logic       r_bond_en = 1'b0;
    logic       r_master_sel = 1'b0;
    logic       r_double_read = 1'b0;
    logic [7:0] r_rd_delay = 8'd0;
    logic [7:0] r_align_timeout = 8'd0;
    logic       wr_started = 1'b0;
    logic       fifo_empty = 1'b0;
    logic       comp_rden_en = 1'b0;
    logic       master_in_rden, rd_phase, rd_align_done, bond_err;
    logic [2:0] bond_state;

    int n_chk = 0;
    int n_err = 0;

    hdpldadapt_rx_cp_bond_rdctl #(.CNTWIDTH(8)) dut (
        .rx_rdfifo_clk       (clk),
        .rx_rdfifo_clk_rst_n (rst_n),
        .rd_srst_n           (rd_srst_n),
        .r_bond_en           (r_bond_en),
        .r_master_sel        (r_master_sel),
        .r_double_read       (r_double_read),
        .r_rd_delay          (r_rd_delay),
        .r_align_timeout     (r_align_timeout),
        .wr_started          (wr_started),
        .fifo_empty          (fifo_empty),
        .comp_rden_en        (comp_rden_en),
        .master_in_rden      (master_in_rden),
        .rd_phase            (rd_phase),
        .rd_align_done       (rd_align_done),
        .bond_err            (bond_err),
        .bond_state          (bond_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int st, input int mr,
                           input int ad, input int ph, input int er);
        chk({tag, ".state"}, 32'(bond_state), st);
        chk({tag, ".rden"},  32'(master_in_rden), mr);
        chk({tag, ".align"}, 32'(rd_align_done), ad);
        chk({tag, ".phase"}, 32'(rd_phase), ph);
        chk({tag, ".err"},   32'(bond_err), er);
    endtask

    // advance to just after the next rising edge (input drive point)
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // sample point: falling edge
    task automatic smp();
        @(negedge clk);
    endtask

    // synchronous reset pulse with data inputs idle
    task automatic sreset();
        rd_srst_n    = 1'b0;
        wr_started   = 1'b0;
        comp_rden_en = 1'b0;
        fifo_empty   = 1'b0;
        step();
        rd_srst_n = 1'b1;
    endtask

    initial begin
        // reset state
        step(); step();
        smp();
        chk_out("reset", 0, 0, 0, 0, 0);
        step();
        rst_n     = 1'b1;
        r_bond_en = 1'b1;

        // master, delay 3, timeout 10, double-read; comp returns so that
        // alignment lands two cycles after the master enable
        r_master_sel = 1'b1; r_double_read = 1'b1;
        r_rd_delay = 8'd3; r_align_timeout = 8'd10;
        sreset();
        wr_started = 1'b1;                       // cycle 0
        for (int k = 1; k <= 4; k++) begin
            step(); smp();
            chk($sformatf("m.delay%0d.state", k), 32'(bond_state), 1);
            chk($sformatf("m.delay%0d.rden", k), 32'(master_in_rden), 0);
        end
        step(); smp();
        chk_out("m.arm_c5", 2, 1, 0, 0, 0);
        step(); comp_rden_en = 1'b1; smp();
        chk_out("m.arm_c6", 2, 1, 0, 0, 0);
        step(); smp();
        chk_out("m.run_c7", 3, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(); smp();
            chk($sformatf("m.phase%0d", i), 32'(rd_phase), (i % 2 == 0) ? 1 : 0);
        end
        // underflow: fifo_empty with comp enable for one cycle
        step(); fifo_empty = 1'b1;
        step(); fifo_empty = 1'b0; comp_rden_en = 1'b0;
        smp();
        chk_out("m.underflow", 4, 0, 0, 0, 1);
        step(); step(); step(); smp();
        chk_out("m.err_hold", 4, 0, 0, 0, 1);
        sreset(); smp();
        chk_out("m.srst", 0, 0, 0, 0, 0);

        // timeout: delay 0 (one DELAY cycle), timeout 4 -> 5 ARM cycles
        r_double_read = 1'b0; r_rd_delay = 8'd0; r_align_timeout = 8'd4;
        wr_started = 1'b1;
        step(); smp();
        chk("to.delay1.state", 32'(bond_state), 1);
        for (int k = 0; k < 5; k++) begin
            step(); smp();
            chk($sformatf("to.arm%0d.state", k), 32'(bond_state), 2);
            chk($sformatf("to.arm%0d.rden", k), 32'(master_in_rden), 1);
        end
        step(); smp();
        chk_out("to.err", 4, 0, 0, 0, 1);
        step(); step(); smp();
        chk_out("to.err_hold", 4, 0, 0, 0, 1);
        // enable drop leaves ERR but bond_err stays sticky
        step(); r_bond_en = 1'b0;
        step(); smp();
        chk_out("to.en_drop", 0, 0, 0, 0, 1);
        step(); r_bond_en = 1'b1;
        sreset(); smp();
        chk_out("to.srst", 0, 0, 0, 0, 0);

        // RUN with single-read: phase stays 0; then enable drop mid-RUN
        r_rd_delay = 8'd0; r_align_timeout = 8'd10;
        wr_started = 1'b1; comp_rden_en = 1'b1;
        step(); step(); step(); smp();
        chk_out("sr.run", 3, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(); smp();
            chk($sformatf("sr.phase%0d", i), 32'(rd_phase), 0);
        end
        step(); r_bond_en = 1'b0;
        step(); smp();
        chk_out("sr.en_drop", 0, 0, 0, 0, 0);
        step(); r_bond_en = 1'b1;
        sreset();

        // slave: same stimulus as the first test, rden never asserts
        r_master_sel = 1'b0; r_rd_delay = 8'd3; r_align_timeout = 8'd10;
        wr_started = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(); smp();
            chk($sformatf("sl.c%0d.rden", k), 32'(master_in_rden), 0);
        end
        chk("sl.c5.state", 32'(bond_state), 2);
        step(); comp_rden_en = 1'b1; smp();
        chk("sl.c6.rden", 32'(master_in_rden), 0);
        step(); smp();
        chk_out("sl.run", 3, 0, 1, 0, 0);
        sreset();

        // async reset in the middle of DELAY
        r_master_sel = 1'b1;
        wr_started = 1'b1;
        step(); step(); smp();
        chk("ar.delay.state", 32'(bond_state), 1);
        #2 rst_n = 1'b0;
        #1 chk_out("ar.async", 0, 0, 0, 0, 0);
        step(); rst_n = 1'b1;
        step(); smp();
        chk("wd.delay.state", 32'(bond_state), 1);
        // write activity vanishing in DELAY returns to IDLE
        step(); wr_started = 1'b0;
        step(); smp();
        chk_out("wd.idle", 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
